seq_tx: RTL

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_tx.sv
// ---------------------------------------------------------------------------
// seq_tx -- fixed-format serial byte transmitter.
//
// Frame on line 'a': start0 (0), start1 (1), 8 data bits LSB first, optional
// even-parity bit, stop (1). The line idles high, so the 0-then-1 start pair
// gives a downstream 0-then-1 pattern detector one hit per frame, right after
// START1.
//
// Build option:
//   SEQ_TX_PARITY_EN  define to insert an even-parity bit (XOR of the data
//                     byte) between the last data bit and STOP. Left
//                     undefined, the parity state and its logic are absent.
//
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   asynchronous, active-high reset
//   data_in  in   [7:0] byte to send, sampled only at the accept edge
//   valid    in   producer has a byte on data_in
//   ready    out  block can accept a byte (IDLE only)
//   a        out  serial line, registered, idle-high
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse, high exactly while a carries STOP
// ---------------------------------------------------------------------------
module seq_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       a,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START0 = 3'd1,
        START1 = 3'd2,
        DATA   = 3'd3,
`ifdef SEQ_TX_PARITY_EN
        PAR    = 3'd4,
`endif
        STOP   = 3'd5
    } state_t;

    state_t     state;
    logic [7:0] sr;
    logic [2:0] cnt;
`ifdef SEQ_TX_PARITY_EN
    logic       par;
`endif

    // All outputs are registered alongside the state: every branch that picks
    // the next state also loads that state's line value and flags, so a and
    // the flags show the new state in the cycle after the transition edge and
    // nothing combinational reaches them from valid or data_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a     <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            sr    <= 8'h00;
            cnt   <= 3'd0;
`ifdef SEQ_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid && ready) begin
                        sr    <= data_in;
`ifdef SEQ_TX_PARITY_EN
                        // Captured at accept: the shift register is emptied
                        // by the time the parity bit goes out.
                        par   <= ^data_in;
`endif
                        state <= START0;
                        a     <= 1'b0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        a     <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                START0: begin
                    state <= START1;
                    a     <= 1'b1;
                end
                START1: begin
                    state <= DATA;
                    cnt   <= 3'd0;
                    a     <= sr[0];
                end
                DATA: begin
                    sr <= {1'b0, sr[7:1]};
                    if (cnt == 3'd7) begin
`ifdef SEQ_TX_PARITY_EN
                        state <= PAR;
                        a     <= par;
`else
                        state <= STOP;
                        a     <= 1'b1;
                        done  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 3'd1;
                        // Next bit on the line is the LSB after this shift.
                        a   <= sr[1];
                    end
                end
`ifdef SEQ_TX_PARITY_EN
                PAR: begin
                    state <= STOP;
                    a     <= 1'b1;
                    done  <= 1'b1;
                end
`endif
                STOP: begin
                    state <= IDLE;
                    a     <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    // Unused encodings fall back to a quiet, idle-high line.
                    state <= IDLE;
                    a     <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
